// File: rtl/pct_trg_pkg.sv
// Shared definitions for the trigger stretcher / coincidence slice.
package pct_trg_pkg;

  localparam int unsigned DEF_CNTW = 8;
  localparam int unsigned MAX_NCH  = 16;

  // One-hot channel states
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_DELAY  = 4'b0010,
    ST_ACTIVE = 4'b0100,
    ST_HOLD   = 4'b1000
  } chan_state_e;

  // Number of set bits in a vector of up to MAX_NCH channels
  function automatic logic [4:0] popcount(input logic [MAX_NCH-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_NCH; i++) begin
      n = n + {4'b0000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/trg_stretch_chan.sv
// Single trigger channel: input sampling, rising-edge detect, and a
// delay / stretch / holdoff sequencer driving one TrgPls bit.
module trg_stretch_chan
  import pct_trg_pkg::*;
#(
  parameter int unsigned CNTW = DEF_CNTW
) (
  input  logic            Clock,
  input  logic            ResetN,
  input  logic            Enable,
  input  logic            TReqIn,
  input  logic [CNTW-1:0] TrgDly,
  input  logic [CNTW-1:0] TrgLen,
  input  logic [CNTW-1:0] HoldOff,
  output logic            TrgPls
);

  localparam logic [CNTW-1:0] ONE = CNTW'(1);

  chan_state_e     state_q, state_d;
  logic            s_q, s_d;
  logic            p_q, p_d;
  logic            armed_q, armed_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] dly_q, dly_d;
  logic [CNTW-1:0] len_q, len_d;
  logic [CNTW-1:0] hold_q, hold_d;
  logic            edge_det;

  // Input sampling and edge qualification.
  // armed only sets once a low level has been sampled, so an input that is
  // already high when reset releases does not count as an edge.
  always_comb begin
    s_d      = TReqIn;
    p_d      = s_q;
    armed_d  = armed_q | ~TReqIn;
    edge_det = s_q & ~p_q & Enable & armed_q;
  end

  // Sequencer next state; counter runs 0..N-1 in each timed state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + ONE;
    dly_d   = dly_q;
    len_d   = len_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (edge_det) begin
          dly_d   = TrgDly;
          len_d   = (TrgLen == '0) ? ONE : TrgLen;
          hold_d  = HoldOff;
          state_d = (TrgDly == '0) ? ST_ACTIVE : ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (cnt_q == dly_q - ONE) begin
          cnt_d   = '0;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (cnt_q == len_q - ONE) begin
          cnt_d   = '0;
          state_d = (hold_q != '0) ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == hold_q - ONE) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Channel registers
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= ST_IDLE;
      s_q     <= 1'b0;
      p_q     <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      dly_q   <= '0;
      len_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      p_q     <= p_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
    end
  end

  assign TrgPls = (state_q == ST_ACTIVE);

endmodule

// File: rtl/trg_stretch_coinc.sv
// Multi-channel trigger stretcher with registered majority coincidence.
module trg_stretch_coinc
  import pct_trg_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned CNTW = DEF_CNTW,
  parameter int unsigned THW  = 5
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic                Enable,
  input  logic [NCH-1:0]      TReqIn,
  input  logic [NCH*CNTW-1:0] TrgDly,
  input  logic [NCH*CNTW-1:0] TrgLen,
  input  logic [CNTW-1:0]     HoldOff,
  input  logic [NCH-1:0]      ChanMask,
  input  logic [THW-1:0]      Thresh,
  output logic [NCH-1:0]      TrgPls,
  output logic                CoincOut,
  output logic                CoincRise
);

  logic [NCH-1:0]     pls;
  logic [MAX_NCH-1:0] masked;
  logic [4:0]         n_act;
  logic               coinc_q, coinc_d;
  logic               rise_q, rise_d;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    trg_stretch_chan #(
      .CNTW(CNTW)
    ) u_chan (
      .Clock  (Clock),
      .ResetN (ResetN),
      .Enable (Enable),
      .TReqIn (TReqIn[i]),
      .TrgDly (TrgDly[i*CNTW +: CNTW]),
      .TrgLen (TrgLen[i*CNTW +: CNTW]),
      .HoldOff(HoldOff),
      .TrgPls (pls[i])
    );
  end

  // Count masked active channels and compare against the threshold
  always_comb begin
    masked           = '0;
    masked[NCH-1:0]  = pls & ChanMask;
    n_act            = popcount(masked);
    coinc_d          = (Thresh != '0) && (32'(n_act) >= 32'(Thresh));
    rise_d           = coinc_d & ~coinc_q;
  end

  // Coincidence level and rising-edge pulse registers
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      coinc_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      coinc_q <= coinc_d;
      rise_q  <= rise_d;
    end
  end

  assign TrgPls    = pls;
  assign CoincOut  = coinc_q;
  assign CoincRise = rise_q;

endmodule

// File: tb/tb_trg_stretch_coinc.sv
// Scoreboard bench for trg_stretch_coinc: a window-based reference model
// pushes the expected outputs for every cycle, a negedge monitor pops them.
module tb_trg_stretch_coinc;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CNTW = 8;
  localparam int unsigned THW  = 5;

  logic                Clock = 1'b0;
  logic                ResetN;
  logic                Enable;
  logic [NCH-1:0]      TReqIn;
  logic [NCH*CNTW-1:0] TrgDly;
  logic [NCH*CNTW-1:0] TrgLen;
  logic [CNTW-1:0]     HoldOff;
  logic [NCH-1:0]      ChanMask;
  logic [THW-1:0]      Thresh;
  logic [NCH-1:0]      TrgPls;
  logic                CoincOut;
  logic                CoincRise;

  trg_stretch_coinc #(
    .NCH (NCH),
    .CNTW(CNTW),
    .THW (THW)
  ) dut (
    .Clock    (Clock),
    .ResetN   (ResetN),
    .Enable   (Enable),
    .TReqIn   (TReqIn),
    .TrgDly   (TrgDly),
    .TrgLen   (TrgLen),
    .HoldOff  (HoldOff),
    .ChanMask (ChanMask),
    .Thresh   (Thresh),
    .TrgPls   (TrgPls),
    .CoincOut (CoincOut),
    .CoincRise(CoincRise)
  );

  always #5 Clock = ~Clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [NCH-1:0] pls;
    logic           coinc;
    logic           rise;
  } exp_t;

  exp_t sb[$];
  bit   started = 0;

  // Monitor-side counters of observed DUT activity
  int rise_cnt[NCH];
  int hi_cnt[NCH];
  int crise_cnt = 0;
  int chigh_cnt = 0;

  // Reference model: each channel is a pulse window [st, en] plus a busy
  // horizon; an edge at cycle t is taken only if t > busy.
  initial begin : model
    logic [NCH-1:0] s_m, p_m, armed_m, prev_pls;
    logic           coinc_m;
    longint         st[NCH], en[NCH], busy[NCH];
    longint         cyc;
    s_m = '0; p_m = '0; armed_m = '0; prev_pls = '0; coinc_m = 1'b0; cyc = 0;
    for (int i = 0; i < NCH; i++) begin st[i] = 1; en[i] = 0; busy[i] = -1; end
    forever begin
      @(posedge Clock);
      if (!ResetN) begin
        s_m = '0; p_m = '0; armed_m = '0; prev_pls = '0; coinc_m = 1'b0;
        for (int i = 0; i < NCH; i++) begin st[i] = 1; en[i] = 0; busy[i] = -1; end
        cyc++;
        sb.push_back('0);
      end else begin
        exp_t   e;
        int     n;
        logic   cn;
        for (int i = 0; i < NCH; i++) begin
          if (s_m[i] && !p_m[i] && Enable && armed_m[i] && cyc > busy[i]) begin
            longint d, l, h;
            d = longint'(TrgDly[i*CNTW +: CNTW]);
            l = longint'(TrgLen[i*CNTW +: CNTW]);
            if (l == 0) l = 1;
            h = longint'(HoldOff);
            st[i]   = cyc + 1 + d;
            en[i]   = cyc + d + l;
            busy[i] = cyc + d + l + h;
          end
          armed_m[i] = armed_m[i] | ~TReqIn[i];
          p_m[i]     = s_m[i];
          s_m[i]     = TReqIn[i];
        end
        n  = $countones(prev_pls & ChanMask);
        cn = (Thresh != 0) && (n >= int'(Thresh));
        e.rise  = cn & ~coinc_m;
        e.coinc = cn;
        coinc_m = cn;
        cyc++;
        for (int i = 0; i < NCH; i++) e.pls[i] = (cyc >= st[i]) && (cyc <= en[i]);
        prev_pls = e.pls;
        sb.push_back(e);
      end
      started = 1;
    end
  end

  // Monitor: compare DUT against the scoreboard mid-cycle
  initial begin : monitor
    logic [NCH-1:0] prev_obs;
    exp_t           e;
    prev_obs = '0;
    for (int i = 0; i < NCH; i++) begin rise_cnt[i] = 0; hi_cnt[i] = 0; end
    forever begin
      @(negedge Clock);
      if (sb.size() == 0) begin
        if (started) chk("sb_underflow", 32'(0), 32'(1));
      end else begin
        e = sb.pop_front();
        if (!ResetN) e = '0;
        chk("trg_pls", 32'(TrgPls), 32'(e.pls));
        chk("coinc_out", 32'(CoincOut), 32'(e.coinc));
        chk("coinc_rise", 32'(CoincRise), 32'(e.rise));
      end
      for (int i = 0; i < NCH; i++) begin
        if (TrgPls[i] && !prev_obs[i]) rise_cnt[i]++;
        if (TrgPls[i]) hi_cnt[i]++;
      end
      if (CoincRise) crise_cnt++;
      if (CoincOut) chigh_cnt++;
      prev_obs = TrgPls;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic set_ch(input int ch, input int d, input int l);
    TrgDly[ch*CNTW +: CNTW] = CNTW'(d);
    TrgLen[ch*CNTW +: CNTW] = CNTW'(l);
  endtask

  initial begin : stim
    int b_r, b_h, b_cr, b_ch;
    ResetN = 1'b0; Enable = 1'b1; TReqIn = '0;
    TrgDly = '0; TrgLen = '0; HoldOff = '0; ChanMask = '1; Thresh = '0;
    tick(3);
    chk("reset_pls", 32'(TrgPls), 32'(0));
    chk("reset_coinc", 32'(CoincOut), 32'(0));
    ResetN = 1'b1;
    tick(2);

    // 1: D=0 L=1 H=0, two single-cycle pulses two cycles apart
    HoldOff = 0; set_ch(0, 0, 1);
    b_r = rise_cnt[0];
    TReqIn[0] = 1; tick(1); TReqIn[0] = 0; tick(1); TReqIn[0] = 1; tick(1); TReqIn[0] = 0;
    tick(6);
    chk("t1_npulse", 32'(rise_cnt[0] - b_r), 32'(2));

    // re-arm boundary: L=2 H=1, edges every 2 cycles; only every other is taken
    HoldOff = 1; set_ch(0, 0, 2);
    b_r = rise_cnt[0];
    for (int k = 0; k < 6; k++) begin TReqIn[0] = 1; tick(1); TReqIn[0] = 0; tick(1); end
    tick(6);
    chk("rearm_npulse", 32'(rise_cnt[0] - b_r), 32'(3));

    // 2: held-high input, D=5 L=3 H=4
    HoldOff = 4; set_ch(1, 5, 3);
    b_r = rise_cnt[1]; b_h = hi_cnt[1];
    TReqIn[1] = 1; tick(20); TReqIn[1] = 0; tick(4);
    chk("t2_npulse", 32'(rise_cnt[1] - b_r), 32'(1));
    chk("t2_len", 32'(hi_cnt[1] - b_h), 32'(3));

    // 3: second edge during DELAY ignored, length change mid-flight ignored
    HoldOff = 10; set_ch(2, 2, 4);
    b_r = rise_cnt[2]; b_h = hi_cnt[2];
    TReqIn[2] = 1; tick(1); TReqIn[2] = 0; tick(1);
    set_ch(2, 2, 1); tick(1);
    TReqIn[2] = 1; tick(1); TReqIn[2] = 0;
    tick(20);
    chk("t3_npulse", 32'(rise_cnt[2] - b_r), 32'(1));
    chk("t3_len", 32'(hi_cnt[2] - b_h), 32'(4));

    // 4: coincidence with mask and thresholds
    HoldOff = 0; Thresh = 2; ChanMask = 4'b0111;
    for (int c = 0; c < NCH; c++) set_ch(c, 0, 6);
    b_cr = crise_cnt; b_ch = chigh_cnt;
    TReqIn = 4'b1001; tick(1); TReqIn = '0; tick(10);
    chk("t4_masked", 32'(chigh_cnt - b_ch), 32'(0));
    b_cr = crise_cnt; b_ch = chigh_cnt;
    TReqIn = 4'b0001; tick(2); TReqIn = 4'b0011; tick(1); TReqIn = '0; tick(12);
    chk("t4_rise", 32'(crise_cnt - b_cr), 32'(1));
    chk("t4_len", 32'(chigh_cnt - b_ch), 32'(4));
    ChanMask = 4'b1111;
    for (int th = 0; th < 3; th++) begin
      Thresh = (th == 0) ? 5'd0 : (th == 1) ? 5'd5 : 5'd4;
      b_cr = crise_cnt;
      TReqIn = 4'b1111; tick(1); TReqIn = '0; tick(10);
      chk("t4_thresh", 32'(crise_cnt - b_cr), (th == 2) ? 32'(1) : 32'(0));
    end

    // 5: asynchronous reset mid-pulse, held input after release
    Thresh = 1; ChanMask = 4'b0010; set_ch(1, 0, 20);
    TReqIn[1] = 1; tick(6);
    chk("t5_pre_coinc", 32'(CoincOut), 32'(1));
    #1 ResetN = 1'b0;
    #1;
    chk("t5_rst_pls", 32'(TrgPls), 32'(0));
    chk("t5_rst_coinc", 32'(CoincOut), 32'(0));
    chk("t5_rst_rise", 32'(CoincRise), 32'(0));
    tick(2); ResetN = 1'b1;
    b_r = rise_cnt[1];
    tick(10);
    chk("t5_held", 32'(rise_cnt[1] - b_r), 32'(0));
    TReqIn[1] = 0; tick(2); TReqIn[1] = 1; tick(25); TReqIn[1] = 0; tick(2);
    chk("t5_retrig", 32'(rise_cnt[1] - b_r), 32'(1));

    // 6: maximum delay and length, Enable dropped mid-flight
    Thresh = 0; HoldOff = 0; set_ch(3, 255, 255);
    b_r = rise_cnt[3]; b_h = hi_cnt[3];
    TReqIn[3] = 1; tick(10); Enable = 0; tick(5); TReqIn[3] = 0;
    tick(520);
    chk("t6_len", 32'(hi_cnt[3] - b_h), 32'(255));
    TReqIn[3] = 1; tick(5); TReqIn[3] = 0; tick(10);
    chk("t6_npulse", 32'(rise_cnt[3] - b_r), 32'(1));
    Enable = 1; tick(2);

    // random traffic with short configurations
    for (int k = 0; k < 400; k++) begin
      if (k % 40 == 0) begin
        for (int c = 0; c < NCH; c++) set_ch(c, $urandom_range(0, 3), $urandom_range(0, 3));
        HoldOff  = CNTW'($urandom_range(0, 3));
        Thresh   = THW'($urandom_range(0, 5));
        ChanMask = NCH'($urandom);
      end
      TReqIn = NCH'($urandom);
      Enable = ($urandom_range(0, 7) != 0);
      tick(1);
    end
    TReqIn = '0; tick(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/trg_stretch_coinc.md
Name: trg_stretch_coinc

Overview:
Multi-channel successor to the single-channel fast-OR stretcher. For each of NCH front-end fast-OR inputs, the block detects a rising edge, delays it by a per-channel count, and stretches it to a per-channel length, followed by a global holdoff. It also forms a registered majority coincidence of the masked, stretched pulses. It sits between the front-end fast-OR inputs and the event-builder trigger logic.

Parameters:
NCH, 4, number of trigger channels (1..16)
CNTW, 8, width of the delay, length and holdoff counters
THW, 5, width of Thresh; must satisfy 2^THW > NCH

Ports:
Clock  in  1  system clock
ResetN  in  1  asynchronous, active-low reset
Enable  in  1  1 = accept new edges; 0 = ignore new edges, but in-flight pulses complete
TReqIn  in  NCH  fast-OR inputs, one per channel
TrgDly  in  NCH*CNTW  per-channel delay; channel i occupies bits [i*CNTW +: CNTW]
TrgLen  in  NCH*CNTW  per-channel pulse length, same packing; 0 is treated as 1
HoldOff  in  CNTW  dead cycles after each pulse, common to all channels
ChanMask  in  NCH  1 = channel participates in the coincidence
Thresh  in  THW  minimum number of active masked channels; 0 disables the coincidence
TrgPls  out  NCH  stretched, delayed per-channel pulses
CoincOut  out  1  registered coincidence level
CoincRise  out  1  one-cycle pulse on each 0->1 transition of CoincOut

Behaviour:
- Reset: ResetN low asynchronously clears TrgPls=0, CoincOut=0, CoincRise=0, all channels to IDLE, all counters and input samples to 0. Reset may occur mid-pulse; the output drops immediately.
- Input sampling:
  - Each TReqIn bit is registered once into S; S is also delayed one cycle into P.
  - An edge exists in cycle t when S=1, P=0 and Enable=1.
  - A held-high input yields exactly one edge.
- Per-channel FSM (one-hot): IDLE, DELAY, ACTIVE, HOLD.
  - IDLE:
    - On an edge, latch D=TrgDly[i], L=max(TrgLen[i],1) and H=HoldOff.
    - Go to ACTIVE if D==0, otherwise to DELAY.
    - Clear the counter.
  - DELAY: count D cycles, then ACTIVE.
  - ACTIVE: TrgPls[i]=1 for exactly L cycles, then HOLD if H>0, otherwise IDLE.
  - HOLD: count H cycles, then IDLE.
  - Edges arriving in DELAY, ACTIVE or HOLD are discarded; there is no queueing or retrigger.
- Latency:
  - Edge seen at cycle t: TrgPls[i] high in cycles t+1+D through t+D+L inclusive, where D and L are the latched values.
  - Earliest possible re-arm is IDLE at cycle t+D+L+H+1; an edge on that cycle is accepted.
- Configuration: TrgDly, TrgLen and HoldOff are sampled only at edge acceptance. Changes mid-pulse do not affect the pulse in flight.
- Enable=0 does not abort DELAY, ACTIVE or HOLD.
- Counters: CNTW-bit compare for equality, with no wrap. The maximum value 2^CNTW-1 must be exact.
- Coincidence:
  - N = popcount(TrgPls & ChanMask), computed from the registered TrgPls.
  - CoincOut <= (Thresh!=0) && (N >= Thresh), so CoincOut lags TrgPls by one cycle.
  - CoincRise <= new CoincOut & ~old CoincOut.
  - Thresh > NCH: CoincOut is never asserted.
- Channels are fully independent. Simultaneous edges on all channels are legal and are handled in the same cycle.

Decomposition:
- Shared package pct_trg_pkg holds:
  - the one-hot state constants ST_IDLE, ST_DELAY, ST_ACTIVE, ST_HOLD;
  - the default CNTW;
  - a popcount function.
- One sub-module, trg_stretch_chan: single-channel sampler, edge detect, FSM and counter, with a TrgPls output. It is instantiated NCH times via generate.
- The top level holds only the coincidence popcount, compare and CoincRise registers.

Test Plan:
1. NCH=4, ch0 D=0, L=1, H=0; 1-cycle high on TReqIn[0], edge at t -> TrgPls[0] high only at t+1; re-pulse at t+2 gives a second 1-cycle pulse at t+3.
2. ch1 D=5, L=3, H=4; TReqIn[1] held high 20 cycles from t -> TrgPls[1] high at t+6..t+8 only; exactly one pulse; IDLE at t+13.
3. ch2 D=2, L=4, H=10; second edge 3 cycles after the first -> ignored, one pulse only. Also change TrgLen[2] to 1 during DELAY -> pulse is still 4 cycles.
4. Thresh=2, ChanMask=4'b0111; overlapping pulses on ch0 and ch3 -> CoincOut stays 0. Overlap on ch0 and ch1 -> CoincOut=1 one cycle after the overlap starts, and CoincRise is a single 1-cycle pulse. Thresh=0 or Thresh=5 -> CoincOut always 0.
5. ResetN asserted mid-ACTIVE on ch1 -> TrgPls, CoincOut and CoincRise are 0 immediately, before any clock edge. After release, TReqIn still high -> no pulse until the input goes low and then high again.
6. D=255, L=255 on ch3 -> pulse starts exactly at t+256 and lasts 255 cycles. Enable=0 at t+10 -> the pulse completes; a new edge during Enable=0 -> no pulse.
